// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative multiply/divide unit for the ALU side of the datapath.
// Executes mult (15), multu (16), div (17) and divu (18) over WIDTH
// iterations, then applies sign correction and writes the architectural
// HI/LO registers. The CPU stalls on busy and reads hi/lo directly.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        operation request, sampled only while idle
//   alu_ctrl_in  ALU control code; codes other than 15..18 are ignored
//   op_a, op_b   rs/rt operands, needed only in the start cycle
//   hi_we, lo_we MTHI/MTLO write enables, honoured only when not busy
//   wdata        MTHI/MTLO write data
//   busy         operation in progress
//   done         one-cycle pulse when HI/LO were just updated
//   hi, lo       HI/LO register contents
//
// Configuration macro: MDU_FAST_MUL_EN
//   Defined:   mult/multu use a single-cycle WIDTH x WIDTH multiplier and
//              finish two edges after acceptance; division is unchanged.
//   Undefined: mult/multu use the shift-add loop, no multiplier inferred.

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       alu_ctrl_in,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [4:0] OP_MULT  = 5'd15;
    localparam logic [4:0] OP_MULTU = 5'd16;
    localparam logic [4:0] OP_DIV   = 5'd17;
    localparam logic [4:0] OP_DIVU  = 5'd18;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               res_sign;
    logic               rem_sign;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;

    logic               code_valid;
    logic               code_div;
    logic               code_signed;
    logic               a_neg;
    logic               b_neg;
    logic               accept;
    logic [WIDTH-1:0]   a_mag_in;
    logic [WIDTH-1:0]   b_mag_in;

    // Request decode: signs only count for the signed codes, so unsigned
    // operations latch zero signs and skip all later correction.
    always_comb begin
        code_valid  = (alu_ctrl_in == OP_MULT) || (alu_ctrl_in == OP_MULTU) ||
                      (alu_ctrl_in == OP_DIV)  || (alu_ctrl_in == OP_DIVU);
        code_div    = (alu_ctrl_in == OP_DIV)  || (alu_ctrl_in == OP_DIVU);
        code_signed = (alu_ctrl_in == OP_MULT) || (alu_ctrl_in == OP_DIV);
        a_neg       = code_signed & op_a[WIDTH-1];
        b_neg       = code_signed & op_b[WIDTH-1];
        a_mag_in    = a_neg ? -op_a : op_a;
        b_mag_in    = b_neg ? -op_b : op_b;
        accept      = (state == IDLE) && start && code_valid;
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;

    // Single-cycle product of the latched magnitudes.
    always_comb begin
        fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    end
`else
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;

    // Shift-add step: the multiplier sits in the low half of acc and is
    // consumed LSB first while the partial product grows in the high half.
    // The carry out of the add becomes the new top bit after the shift.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                   (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
        mul_step = {mul_sum, acc[WIDTH-1:1]};
    end
`endif

    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_step;

    // Restoring divide step: the dividend shifts out of the low half into
    // the partial remainder while quotient bits shift in at the bottom.
    // The trial uses WIDTH+1 bits so its top bit is a clean borrow flag.
    always_comb begin
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
        if (div_trial[WIDTH])
            div_step = {acc[2*WIDTH-2:0], 1'b0};
        else
            div_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Sign correction and result selection for the FIX state. A zero
    // divisor forces LO to all ones and hands the dividend back in HI
    // (magnitude with the dividend's sign restored). The most-negative / -1
    // case needs no special handling: the quotient magnitude wraps back
    // to itself when negated.
    always_comb begin
        prod_fixed = res_sign ? -acc : acc;
        quo_fixed  = res_sign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fixed  = rem_sign ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_hi     = prod_fixed[2*WIDTH-1:WIDTH];
        fix_lo     = prod_fixed[WIDTH-1:0];
        if (is_div) begin
            if (mag_b == {WIDTH{1'b0}}) begin
                fix_lo = {WIDTH{1'b1}};
                fix_hi = rem_sign ? -mag_a : mag_a;
            end else begin
                fix_lo = quo_fixed;
                fix_hi = rem_fixed;
            end
        end
    end

    // Control FSM, iteration datapath and HI/LO registers. MTHI/MTLO are
    // gated by busy so they land in IDLE (including the done cycle and a
    // start cycle) and never disturb a running operation; the FIX write
    // then overwrites anything written at the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            res_sign <= 1'b0;
            rem_sign <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            if (!busy && hi_we)
                hi <= wdata;
            if (!busy && lo_we)
                lo <= wdata;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= CALC;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        is_div   <= code_div;
                        res_sign <= a_neg ^ b_neg;
                        rem_sign <= a_neg;
                        mag_a    <= a_mag_in;
                        mag_b    <= b_mag_in;
                        acc      <= {{WIDTH{1'b0}}, code_div ? a_mag_in : b_mag_in};
                    end
                end
                CALC: begin
`ifdef MDU_FAST_MUL_EN
                    if (!is_div) begin
                        acc   <= fast_prod;
                        state <= FIX;
                    end else begin
                        acc <= div_step;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST_ITER)
                            state <= FIX;
                    end
`else
                    acc <= is_div ? div_step : mul_step;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_ITER)
                        state <= FIX;
`endif
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
